// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
//   Pipeline <-> multiply/divide unit handshake bundle.
//   master : pipeline side (drives start/flush/op/operands, sees status/result)
//   slave  : mul_div_unit side
//   Signals:
//     start   launch an operation (sampled only while the unit is idle)
//     flush   synchronous abort of the in-flight operation
//     op      RV32M funct3 (0 MUL .. 7 REMU)
//     src1    rs1: multiplicand / dividend
//     src2    rs2: multiplier / divisor
//     busy    unit is iterating or applying the sign fix
//     done    one-cycle pulse, result valid
//     result  registered result, held until the next accepted start
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  start;
    logic                  flush;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, flush, op, src1, src2,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, src1, src2,
        output busy, done, result
    );
endinterface

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle RV32M multiply/divide unit for the EX stage.
//   Radix-2 iterative core (one bit per cycle): shift-add multiply and
//   restoring divide on operand magnitudes, followed by a single sign-fix
//   cycle. Divide-by-zero and signed overflow finish immediately.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   mul_div_unit_if.slave handshake (start/flush/op/src1/src2 in,
//           busy/done/result out)
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q,  state_d;
    logic [2:0]      op_q,     op_d;
    logic [W-1:0]    a_q,      a_d;       // multiplicand or divisor magnitude
    logic [2*W-1:0]  prod_q,   prod_d;    // {hi, multiplier} or {rem, quot}
    logic            sign1_q,  sign1_d;
    logic            sign2_q,  sign2_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [W-1:0]    result_q, result_d;

    // ------------------------------------------------------------------
    // Operand decode for the launch cycle
    // ------------------------------------------------------------------
    logic         src1_signed, src2_signed;
    logic         neg1, neg2;
    logic [W-1:0] mag1, mag2;
    logic         div_by_zero, div_ovf;

    always_comb begin
        src1_signed = bus.op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        src2_signed = bus.op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        neg1        = src1_signed & bus.src1[W-1];
        neg2        = src2_signed & bus.src2[W-1];
        mag1        = neg1 ? -bus.src1 : bus.src1;
        mag2        = neg2 ? -bus.src2 : bus.src2;
        div_by_zero = bus.op[2] && (bus.src2 == '0);
        div_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                      (bus.src1 == MIN_VAL) && (bus.src2 == '1);
    end

    // ------------------------------------------------------------------
    // Iteration and sign-fix datapath
    // ------------------------------------------------------------------
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_fix;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
        // {rem, quot} shifted left by one, viewed as a W+1-bit partial remainder.
        div_shift = prod_q[2*W-1:W-1];
        // The shifted remainder is below 2*divisor, so the difference always
        // fits in W bits; the top bit only decides whether it is >= divisor.
        div_ge    = div_shift[W] || (div_shift[W-1:0] >= a_q);
        div_diff  = div_shift[W-1:0] - a_q;

        prod_fix  = (sign1_q ^ sign2_q) ? -prod_q : prod_q;
        quot_fix  = (sign1_q ^ sign2_q) ? -prod_q[W-1:0] : prod_q[W-1:0];
        rem_fix   = sign1_q ? -prod_q[2*W-1:W] : prod_q[2*W-1:W];

        if (op_q[2]) begin
            res_fix = op_q[1] ? rem_fix : quot_fix;
        end else begin
            res_fix = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        prod_d   = prod_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.op;
                    sign1_d = neg1;
                    sign2_d = neg2;
                    cnt_d   = '0;
                    if (bus.op[2]) begin
                        a_d    = mag2;
                        prod_d = {{W{1'b0}}, mag1};
                    end else begin
                        a_d    = mag1;
                        prod_d = {{W{1'b0}}, mag2};
                    end

                    if (div_by_zero) begin
                        result_d = bus.op[1] ? bus.src1 : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = bus.op[1] ? '0 : MIN_VAL;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end

            S_CALC: begin
                if (op_q[2]) begin
                    prod_d = div_ge ? {div_diff, prod_q[W-2:0], 1'b1}
                                    : {div_shift[W-1:0], prod_q[W-2:0], 1'b0};
                end else begin
                    prod_d = {mul_sum, prod_q[W-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                result_d = res_fix;
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a result load in FIX.
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            prod_q   <= prod_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
//   Self-checking bench for mul_div_unit at DATA_WIDTH = 32. Expected results
//   come from plain 64-bit arithmetic on the RV32M rules.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
    localparam int unsigned W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam int NORMAL_LAT = W + 1;  // edges after the sampling edge

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mul_div_unit_if #(.DATA_WIDTH(W)) bus ();

    mul_div_unit #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32M reference results
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint     sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (o)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == MINV && b == 32'hFFFF_FFFF) r = MINV;
                else begin p = 64'(sa / sb); r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = 64'(ua / ub); r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MINV && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = 64'(sa % sb); r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = 64'(ua % ub); r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 0;
        if ((o == 3'd4 || o == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 0;
        return NORMAL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0;
            1: v = MINV;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h1;
            4: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Launch one op and wait for done. lat = edges after the sampling edge
    // until done is seen; busy_cnt = cycles with busy high before done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cnt);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src1  = a;
        bus.src2  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.src1  = $urandom;
        bus.src2  = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.src1 = '0; bus.src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat, bc;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, bc);
        n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_result got=%h exp=ffffffeb", res); end
        n_cmp++; if (lat != NORMAL_LAT) begin n_err++; $display("FAIL mul_latency got=%0d exp=%0d", lat, NORMAL_LAT); end
        n_cmp++; if (bc != NORMAL_LAT) begin n_err++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", bc, NORMAL_LAT); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got=%b exp=0", bus.done); end
    endtask

    task automatic test_directed(input string name, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res; int lat, bc;
        run_op(o, a, b, res, lat, bc);
        n_cmp++; if (res !== exp) begin n_err++; $display("FAIL %s result got=%h exp=%h", name, res, exp); end
        n_cmp++; if (lat != exp_lat) begin n_err++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
    endtask

    task automatic test_mulh();
        test_directed("mulh",   3'd1, MINV,         MINV,         32'h4000_0000, NORMAL_LAT);
        test_directed("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORMAL_LAT);
        test_directed("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORMAL_LAT);
    endtask

    task automatic test_div();
        test_directed("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORMAL_LAT);
        test_directed("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORMAL_LAT);
        test_directed("divu", 3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, NORMAL_LAT);
        test_directed("remu", 3'd7, 32'd100,       32'd7, 32'd2,         NORMAL_LAT);
    endtask

    task automatic test_special();
        test_directed("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        test_directed("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5,         0);
        test_directed("div_by0",  3'd4, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 0);
        test_directed("rem_by0",  3'd6, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 0);
        test_directed("div_ovf",  3'd4, MINV, 32'hFFFF_FFFF, MINV,  0);
        test_directed("rem_ovf",  3'd6, MINV, 32'hFFFF_FFFF, 32'h0, 0);
    endtask

    task automatic test_ignore_start();
        int cyc;
        logic [31:0] exp;
        exp = ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd1; bus.src1 = 32'h1234_5678; bus.src2 = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 3'd5; bus.src1 = 32'hDEAD_BEEF; bus.src2 = 32'h3;
        cyc = 0;
        repeat (4) begin @(posedge clk); #1; cyc++; end
        bus.start = 1'b1; bus.op = 3'd7; bus.src1 = 32'd99; bus.src2 = 32'd0;
        @(posedge clk); #1; cyc++;
        bus.start = 1'b0;
        while (!bus.done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        n_cmp++; if (bus.result !== exp) begin n_err++; $display("FAIL ignore_start_result got=%h exp=%h", bus.result, exp); end
        n_cmp++; if (cyc != NORMAL_LAT) begin n_err++; $display("FAIL ignore_start_latency got=%0d exp=%0d", cyc, NORMAL_LAT); end
    endtask

    task automatic test_flush();
        logic [31:0] r0; int lat, bc, seen;
        run_op(3'd5, 32'd100, 32'd7, r0, lat, bc);
        n_cmp++; if (r0 !== 32'd14) begin n_err++; $display("FAIL flush_pre_result got=%h exp=e", r0); end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd0; bus.src1 = 32'd3; bus.src2 = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.result !== 32'd14) begin n_err++; $display("FAIL flush_result got=%h exp=e", bus.result); end
        seen = 0;
        repeat (40) begin if (bus.done) seen++; @(posedge clk); #1; end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        // flush and start together while idle: nothing launches
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.src1 = 32'd5; bus.src2 = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL flush_over_start got busy=%b done=%b exp 0/0", bus.busy, bus.done);
        end
        test_directed("after_flush", 3'd0, 32'd3, 32'd9, 32'd27, NORMAL_LAT);
    endtask

    task automatic test_async_reset();
        int seen;
        test_directed("pre_reset", 3'd0, 32'd3, 32'd5, 32'd15, NORMAL_LAT);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd4; bus.src1 = 32'd1000; bus.src2 = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL areset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL areset_result got=%h exp=0", bus.result); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin if (bus.done || bus.busy) seen++; @(posedge clk); #1; end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL areset_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat, bc;
        logic [2:0]  o [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        o[0] = 3'd6; a[0] = 32'hFFFF_FF00; b[0] = 32'd7;
        o[1] = 3'd0; a[1] = 32'hFFFF_FFFF; b[1] = 32'hFFFF_FFFF;
        o[2] = 3'd4; a[2] = 32'd12345;     b[2] = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            run_op(o[i], a[i], b[i], res, lat, bc);
            n_cmp++; if (res !== ref_model(o[i], a[i], b[i]) || lat != NORMAL_LAT) begin
                n_err++; $display("FAIL b2b_%0d got=%h/%0d exp=%h/%0d", i, res, lat,
                                  ref_model(o[i], a[i], b[i]), NORMAL_LAT);
            end
        end
        // start raised while done is showing is ignored
        bus.start = 1'b1; bus.op = 3'd5; bus.src1 = 32'd9; bus.src2 = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++; $display("FAIL start_in_done got busy=%b done=%b exp 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] res, a, b; logic [2:0] o; int lat, bc;
        for (int i = 0; i < n; i++) begin
            o = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(o, a, b, res, lat, bc);
            n_cmp++; if (res !== ref_model(o, a, b)) begin
                n_err++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", o, a, b, res, ref_model(o, a, b));
            end
            n_cmp++; if (lat != ref_lat(o, a, b)) begin
                n_err++; $display("FAIL rand_latency op=%0d a=%h b=%h got=%0d exp=%0d", o, a, b, lat, ref_lat(o, a, b));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_ignore_start();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random(1200);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
